// File: rtl/ssd_pkg.sv
// Shared definitions for seven-segment display readers: active-low segment
// patterns (g..a), anode select codes and the capture FSM state encoding.
package ssd_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b0100111;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [1:0] SEL_D0 = 2'b10;
  localparam logic [1:0] SEL_D1 = 2'b01;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    TRACK    = 2'd1,
    HELD     = 2'd2
  } state_e;

endpackage

// File: rtl/ssd_seg_decode.sv
// Combinational lookup from an active-low g..a segment pattern to a hex nibble;
// valid_o is low for any of the 112 patterns that are not a hex glyph.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    valid_o  = 1'b1;
    nibble_o = 4'h0;
    case (seg_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_capture_decoder.sv
// Samples an asynchronous multiplexed active-low segment/anode bus, waits for each
// digit to be stable, decodes it and reassembles the {dp, hi, lo} display word.
module ssd_capture_decoder
  import ssd_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SegIn,
  input  logic [1:0] AnIn,
  input  logic       Clear,
  output logic [8:0] DataOut,
  output logic       Valid,
  output logic       Err
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);

  logic [7:0] seg_sync_q [SYNC_STAGES];
  logic [1:0] an_sync_q  [SYNC_STAGES];

  // NOTE: the synchronizer array is reset explicitly (to the idle-high bus) because
  // arrays are not covered by a plain reset of scalar registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        seg_sync_q[i] <= '1;
        an_sync_q[i]  <= '1;
      end
    end else begin
      seg_sync_q[0] <= SegIn;
      an_sync_q[0]  <= AnIn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        seg_sync_q[i] <= seg_sync_q[i-1];
        an_sync_q[i]  <= an_sync_q[i-1];
      end
    end
  end

  logic [7:0] s;
  logic [1:0] a;
  logic [9:0] sample;
  logic       sel_ok;
  logic       dec_valid;
  logic [3:0] dec_nib;

  assign s      = seg_sync_q[SYNC_STAGES-1];
  assign a      = an_sync_q[SYNC_STAGES-1];
  assign sample = {a, s};
  assign sel_ok = (a == SEL_D0) || (a == SEL_D1);

  ssd_seg_decode u_dec (
    .seg_i    (s[6:0]),
    .valid_o  (dec_valid),
    .nibble_o (dec_nib)
  );

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [9:0] ref_q, ref_d;
  logic       accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    accept  = 1'b0;
    if (!sel_ok) begin
      state_d = WAIT_SEL;
      cnt_d   = '0;
    end else if (state_q == WAIT_SEL || sample != ref_q) begin
      ref_d   = sample;
      cnt_d   = 8'd1;
      accept  = (cnt_d == STABLE_W);
      state_d = accept ? HELD : TRACK;
    end else if (state_q == TRACK) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == STABLE_W) begin
        state_d = HELD;
        accept  = 1'b1;
      end
    end
  end

  logic [3:0] lo_q, lo_d, hi_q, hi_d;
  logic       dp_q, dp_d;
  logic       got_lo_q, got_lo_d, got_hi_q, got_hi_d;
  logic [8:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  // The word completes on the accepting edge, so the flags drop together with the pulse.
  always_comb begin
    lo_d     = lo_q;
    hi_d     = hi_q;
    dp_d     = dp_q;
    got_lo_d = got_lo_q;
    got_hi_d = got_hi_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    if (accept) begin
      if (!dec_valid) begin
        err_d = 1'b1;
      end else if (a == SEL_D0) begin
        lo_d     = dec_nib;
        dp_d     = s[7];
        got_lo_d = 1'b1;
      end else begin
        hi_d     = dec_nib;
        got_hi_d = 1'b1;
      end
      if (got_lo_d && got_hi_d) begin
        data_d   = {dp_d, hi_d, lo_d};
        valid_d  = 1'b1;
        got_lo_d = 1'b0;
        got_hi_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the _d values are
  // computed with blocking assignments in the combinational blocks above.
  always_ff @(posedge CLK) begin
    if (RST || Clear) begin
      state_q  <= WAIT_SEL;
      cnt_q    <= '0;
      ref_q    <= '1;
      lo_q     <= '0;
      hi_q     <= '0;
      dp_q     <= 1'b0;
      got_lo_q <= 1'b0;
      got_hi_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dp_q     <= dp_d;
      got_lo_q <= got_lo_d;
      got_hi_q <= got_hi_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign DataOut = data_q;
  assign Valid   = valid_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_ssd_capture_decoder.sv
// Self-checking bench for ssd_capture_decoder: directed scenarios plus a randomized
// run compared cycle by cycle against a run-length behavioural model.
module tb_ssd_capture_decoder;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int LAT           = SYNC_STAGES + STABLE_CYCLES - 1;

  localparam logic [1:0] D0   = 2'b10;
  localparam logic [1:0] D1   = 2'b01;
  localparam logic [1:0] NONE = 2'b11;
  localparam logic [1:0] BOTH = 2'b00;

  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] SegIn;
  logic [1:0] AnIn;
  logic       Clear;
  logic [8:0] DataOut;
  logic       Valid;
  logic       Err;

  always #5 CLK = ~CLK;

  ssd_capture_decoder #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SegIn   (SegIn),
    .AnIn    (AnIn),
    .Clear   (Clear),
    .DataOut (DataOut),
    .Valid   (Valid),
    .Err     (Err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc            = 0;
  int valid_cnt      = 0;
  int last_valid_cyc = -1;
  int mism_cycles    = 0;
  string mism_info   = "";

  // Model: each edge the core sees the pin value from SYNC_STAGES edges ago; a digit
  // is accepted when its run of identical valid-select samples reaches STABLE_CYCLES.
  logic [9:0] hist [SYNC_STAGES];
  logic [9:0] run_val;
  int         run_len;
  logic [3:0] m_lo, m_hi;
  logic       m_dp, m_glo, m_ghi, m_valid, m_err;
  logic [8:0] m_data;

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (PAT[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [7:0] glyph(input int n, input logic dp);
    return {dp, PAT[n]};
  endfunction

  task automatic model_edge(input logic [1:0] an, input logic [7:0] seg,
                            input logic rst, input logic clr);
    logic [9:0] smp;
    int nib;
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) hist[i] = '1;
      run_len = 0; run_val = '1;
      m_lo = '0; m_hi = '0; m_dp = 1'b0; m_glo = 1'b0; m_ghi = 1'b0;
      m_valid = 1'b0; m_err = 1'b0; m_data = '0;
      return;
    end
    smp = hist[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {an, seg};
    m_valid = 1'b0;
    if (clr) begin
      run_len = 0;
      m_glo = 1'b0; m_ghi = 1'b0; m_data = '0; m_err = 1'b0;
      return;
    end
    if (smp[9:8] != D0 && smp[9:8] != D1) begin
      run_len = 0;
      return;
    end
    if (run_len > 0 && smp == run_val) run_len++;
    else begin
      run_val = smp;
      run_len = 1;
    end
    if (run_len != STABLE_CYCLES) return;
    nib = decode(smp[6:0]);
    if (nib < 0) m_err = 1'b1;
    else if (smp[9:8] == D0) begin
      m_lo = nib[3:0]; m_dp = smp[7]; m_glo = 1'b1;
    end else begin
      m_hi = nib[3:0]; m_ghi = 1'b1;
    end
    if (m_glo && m_ghi) begin
      m_data = {m_dp, m_hi, m_lo};
      m_valid = 1'b1;
      m_glo = 1'b0; m_ghi = 1'b0;
    end
  endtask

  task automatic step(input logic [1:0] an, input logic [7:0] seg,
                      input logic clr, input logic rst);
    AnIn = an; SegIn = seg; Clear = clr; RST = rst;
    @(posedge CLK);
    model_edge(an, seg, rst, clr);
    #1;
    cyc++;
    if (Valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if ({Valid, Err, DataOut} !== {m_valid, m_err, m_data}) begin
      mism_cycles++;
      mism_info = $sformatf("cycle %0d dut V=%b E=%b D=%h model V=%b E=%b D=%h",
                            cyc, Valid, Err, DataOut, m_valid, m_err, m_data);
    end
  endtask

  task automatic hold(input logic [1:0] an, input logic [7:0] seg, input int n);
    repeat (n) step(an, seg, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    int v0;
    step(NONE, 8'hFF, 1'b0, 1'b1);
    step(NONE, 8'hFF, 1'b0, 1'b1);
    n_checks++;
    if ({Valid, Err, DataOut} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got V=%b E=%b D=%h expected all zero", Valid, Err, DataOut);
    end
    v0 = valid_cnt;
    hold(NONE, 8'hFF, 50);
    n_checks++;
    if (valid_cnt !== v0) begin
      n_fail++;
      $display("FAIL idle_valid: got %0d pulses expected 0", valid_cnt - v0);
    end
    n_checks++;
    if (DataOut !== 9'h000) begin
      n_fail++;
      $display("FAIL idle_dataout: got %h expected 000", DataOut);
    end
    n_checks++;
    if (Err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_err: got %b expected 0", Err);
    end
  endtask

  task automatic test_basic_word();
    int v0, start;
    v0 = valid_cnt;
    hold(D0, glyph(5, 1'b1), 8);
    start = cyc + 1;
    hold(D1, glyph(10, 1'b1), 8);
    n_checks++;
    if (valid_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL basic_pulses: got %0d expected 1", valid_cnt - v0);
    end
    n_checks++;
    if (last_valid_cyc !== start + LAT) begin
      n_fail++;
      $display("FAIL basic_latency: got cycle %0d expected %0d", last_valid_cyc, start + LAT);
    end
    n_checks++;
    if (DataOut !== 9'h1A5) begin
      n_fail++;
      $display("FAIL basic_data: got %h expected 1a5", DataOut);
    end
    n_checks++;
    if (Err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err: got %b expected 0", Err);
    end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = valid_cnt;
    hold(D0, glyph(3, 1'b0), 3);
    hold(D0, glyph(8, 1'b0), 6);
    hold(D1, glyph(0, 1'b1), 6);
    n_checks++;
    if (valid_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL glitch_pulses: got %0d expected 1", valid_cnt - v0);
    end
    n_checks++;
    if (DataOut !== 9'h008) begin
      n_fail++;
      $display("FAIL glitch_data: got %h expected 008", DataOut);
    end
  endtask

  task automatic test_invalid();
    int v0;
    v0 = valid_cnt;
    hold(D0, 8'b1_1111111, 6);
    n_checks++;
    if (Err !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_err_set: got %b expected 1", Err);
    end
    hold(D1, glyph(1, 1'b1), 6);
    n_checks++;
    if (valid_cnt !== v0 || Err !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_no_word: got pulses=%0d err=%b expected 0 and 1", valid_cnt - v0, Err);
    end
    hold(D0, glyph(2, 1'b1), 6);
    n_checks++;
    if (valid_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL invalid_word_pulse: got %0d expected 1", valid_cnt - v0);
    end
    n_checks++;
    if (DataOut !== 9'h112) begin
      n_fail++;
      $display("FAIL invalid_word_data: got %h expected 112", DataOut);
    end
    n_checks++;
    if (Err !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_err_sticky: got %b expected 1", Err);
    end
    step(D0, glyph(2, 1'b1), 1'b1, 1'b0);
    n_checks++;
    if ({Err, DataOut} !== 10'd0) begin
      n_fail++;
      $display("FAIL invalid_clear: got err=%b data=%h expected 0 and 000", Err, DataOut);
    end
  endtask

  task automatic test_simultaneous();
    int v0;
    v0 = valid_cnt;
    hold(D0, glyph(7, 1'b0), 8);
    for (int i = 0; i < 8; i++) step(D1, glyph(9, 1'b1), (i == LAT), 1'b0);
    n_checks++;
    if (valid_cnt !== v0 || DataOut !== 9'h000) begin
      n_fail++;
      $display("FAIL simul_clear_wins: got pulses=%0d data=%h expected 0 and 000", valid_cnt - v0, DataOut);
    end
    hold(D1, glyph(9, 1'b1), 8);
    n_checks++;
    if (valid_cnt !== v0) begin
      n_fail++;
      $display("FAIL simul_gotlo_cleared: got %0d pulses expected 0", valid_cnt - v0);
    end
    hold(D0, glyph(4, 1'b0), 8);
    n_checks++;
    if (valid_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL simul_recover_pulse: got %0d expected 1", valid_cnt - v0);
    end
    n_checks++;
    if (DataOut !== 9'h094) begin
      n_fail++;
      $display("FAIL simul_recover_data: got %h expected 094", DataOut);
    end
  endtask

  task automatic test_mid_reset();
    int v0;
    v0 = valid_cnt;
    hold(BOTH, 8'hFF, 10);
    n_checks++;
    if (Err !== 1'b0 || valid_cnt !== v0) begin
      n_fail++;
      $display("FAIL both_sel_ignored: got err=%b pulses=%0d expected 0 and 0", Err, valid_cnt - v0);
    end
    hold(D0, glyph(6, 1'b1), 6);
    step(D0, glyph(6, 1'b1), 1'b0, 1'b1);
    hold(D1, glyph(11, 1'b1), 10);
    n_checks++;
    if (valid_cnt !== v0 || DataOut !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_discards: got pulses=%0d data=%h expected 0 and 000", valid_cnt - v0, DataOut);
    end
    hold(D0, glyph(14, 1'b1), 8);
    n_checks++;
    if (valid_cnt - v0 !== 1) begin
      n_fail++;
      $display("FAIL reset_recover_pulse: got %0d expected 1", valid_cnt - v0);
    end
    n_checks++;
    if (DataOut !== 9'h1BE) begin
      n_fail++;
      $display("FAIL reset_recover_data: got %h expected 1be", DataOut);
    end
  endtask

  task automatic test_random();
    int v0, sel, dur;
    logic [1:0] an;
    logic [7:0] seg;
    v0 = valid_cnt;
    for (int h = 0; h < 400; h++) begin
      sel = $urandom_range(0, 9);
      an  = (sel < 4) ? D0 : (sel < 8) ? D1 : (sel == 8) ? NONE : BOTH;
      if ($urandom_range(0, 9) < 8) seg = glyph($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      else seg = 8'($urandom);
      dur = $urandom_range(1, 8);
      for (int c = 0; c < dur; c++)
        step(an, seg, ($urandom_range(0, 59) == 0), ($urandom_range(0, 149) == 0));
    end
    n_checks++;
    if (mism_cycles !== 0) begin
      n_fail++;
      $display("FAIL model_compare: got %0d differing cycles expected 0; last %s", mism_cycles, mism_info);
    end
    n_checks++;
    if (valid_cnt - v0 < 1) begin
      n_fail++;
      $display("FAIL random_words: got %0d words expected at least 1", valid_cnt - v0);
    end
  endtask

  initial begin
    RST = 1'b1; Clear = 1'b0; AnIn = NONE; SegIn = 8'hFF;
    #2;
    test_reset();
    test_basic_word();
    test_glitch();
    test_invalid();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd_capture_decoder.md
Name: ssd_capture_decoder

Overview:
- Receive side of the seven-segment display path: it samples a multiplexed, active-low segment/anode bus and decodes the segment patterns back into hex nibbles.
- It reassembles the 9-bit {dp, high nibble, low nibble} word that the display encoder was given.
- Used for on-board loopback checking of the display encoder, and for reading a display bus driven by another board.
- Operates on one clock; the segment/anode inputs are asynchronous to it.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SegIn/AnIn (range 2-3).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required to accept a digit (range 1-255).

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- SegIn  input  8  active-low segments; [6:0]=g..a, [7]=dp.
- AnIn  input  2  active-low digit enables; AnIn[0]=digit0 (DataIn[3:0]), AnIn[1]=digit1 (DataIn[7:4]).
- Clear  input  1  synchronous clear of captured flags, DataOut and Err.
- DataOut  output  9  [8]=dp, [7:4]=digit1 nibble, [3:0]=digit0 nibble.
- Valid  output  1  one-cycle pulse when DataOut is updated.
- Err  output  1  sticky; set on an undecodable stable pattern.

Behaviour:
- Reset: RST=1 at a clock edge sets DataOut=0, Valid=0 and Err=0. It also clears the capture flags GotLo/GotHi, zeroes the stability counter, sets state=WAIT_SEL and fills the synchronizers with 1s (idle bus). RST asserted mid-capture discards partial captures.
- Synchronizer: SegIn and AnIn each pass through SYNC_STAGES flops. Only the synchronized values, S and A, are used below.
- Select decode: A=2'b10 selects digit0; A=2'b01 selects digit1. A=2'b11 (no digit) or 2'b00 (both digits) is an invalid selection.
- FSM states:
  - WAIT_SEL: invalid selection. Counter held at 0. Moves to TRACK on a valid selection, loading the counter with 1 and storing Ref={A,S}.
  - TRACK: counting stability.
    - If {A,S}==Ref, the counter increments. When counter==STABLE_CYCLES, the FSM moves to HELD and performs an accept in the same edge.
    - If {A,S}!=Ref with a valid selection, Ref is reloaded and the counter set to 1 (stay in TRACK).
    - On an invalid selection, the FSM goes to WAIT_SEL.
  - HELD: digit already accepted. No re-accept while {A,S}==Ref. On any change, the FSM behaves as TRACK-restart or WAIT_SEL, per the rules above.
- STABLE_CYCLES=1: a valid selection accepts on the first sample (WAIT_SEL goes directly to HELD).
- Accept:
  - Decode S[6:0] using the table below.
  - Valid pattern: store the nibble into the digit0 or digit1 holding register and set GotLo or GotHi. When digit0 is accepted, also store dp = S[7] (raw, no inversion).
  - Undecodable pattern: set Err; neither the holding register nor its flag changes.
- Decode table, S[6:0] to nibble:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3
  - 0011001=4, 0010010=5, 0000010=6, 1111000=7
  - 0000000=8, 0010000=9, 0001000=A, 0000011=b
  - 0100111=c, 0100001=d, 0000110=E, 0001110=F
  - All other 112 codes are invalid.
- Word completion: on the edge where an accept makes GotLo and GotHi both true, DataOut is loaded from the holding registers (including the just-accepted nibble). On the next cycle Valid=1 for exactly one cycle, and GotLo and GotHi are cleared.
- Re-accepting the same digit before the other digit arrives overwrites its holding register. This is not an error.
- Latency: input pins stable at edge k gives Valid=1 during the cycle after edge k+SYNC_STAGES+STABLE_CYCLES-1. With the defaults, Valid is high 6 cycles after the pin change.
- Clear: same effect as RST except that the synchronizers are not cleared.
  - Clear takes priority over a simultaneous accept; that accept is lost.
  - The FSM goes to WAIT_SEL.
- Err is cleared only by RST or Clear. Err and Valid may both be asserted.

Decomposition:
- Shared package (ssd_pkg):
  - Segment pattern constants SEG_0..SEG_F (7-bit, active-low, g..a).
  - FSM state encoding: WAIT_SEL, TRACK, HELD.
  - Anode select constants: SEL_D0=2'b10, SEL_D1=2'b01.
- One natural sub-module, ssd_seg_decode: combinational pattern-to-{valid, nibble} lookup. It is reused by any later segment readers.

Test Plan:
- Reset and idle:
  - Stimulus: RST pulse, then AnIn=11 and SegIn=FF for 50 cycles.
  - Required: DataOut=0, Valid never asserted, Err=0.
- Basic word:
  - Stimulus: drive AnIn=10, SegIn=8'b1_0010010 (digit0 '5', dp=1) for 8 cycles, then AnIn=01, SegIn=8'b1_0001000 (digit1 'A') for 8 cycles.
  - Required: a single Valid pulse with DataOut=9'h1A5, exactly 6 cycles after the digit1 inputs are applied.
- Glitch rejection:
  - Stimulus: digit0 '3' held 3 cycles, then '8' held 6 cycles, then digit1 '0' held 6 cycles.
  - Required: DataOut[3:0]=8 (the '3' is never accepted), DataOut=9'h008.
- Invalid pattern:
  - Stimulus: digit0 SegIn=8'b1_1111111 held 6 cycles, then valid digit1 '1'.
  - Required: Err=1 sticky and no Valid. After digit0 '2' is held 6 cycles, Valid with DataOut=9'h112 and Err still 1; Clear then sets Err=0.
- Simultaneous events:
  - Stimulus: assert Clear on the exact edge the digit1 accept would occur.
  - Required: no Valid, DataOut=0, GotLo cleared. A fresh digit0 + digit1 sequence then produces Valid normally.
- Mid-operation reset and bad select:
  - Stimulus: AnIn=00 for 10 cycles, then valid digit0; assert RST after digit0 is accepted; then send only digit1.
  - Required: AnIn=00 produces no accept; no Valid after RST until both digits are re-captured.
